qram_arbiter: RTL and testbench

QRAM_ARBITER -- requirements
Module: qram_arbiter

---
 rtl/qram_arbiter_if.sv | 43 ++++
 rtl/qram_arbiter.sv | 107 ++++++++++
 tb/tb_qram_arbiter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/qram_arbiter_if.sv
// rtl/qram_arbiter_if.sv - requester and RAM-controller bundle for qram_arbiter
interface qram_arbiter_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]     req;
  logic [NREQ-1:0]     req_wen;
  logic [NREQ-1:0]     req_four;
  logic [NREQ-1:0]     req_lock;
  logic [NREQ*16-1:0]  req_addr;
  logic [NREQ*128-1:0] req_din;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     rvalid;
  logic [127:0]        rdata;
  logic                ram_wen;
  logic                ram_ren;
  logic                ram_four;
  logic [15:0]         ram_addr;
  logic [31:0]         ram_din_a;
  logic [31:0]         ram_din_b;
  logic [31:0]         ram_din_c;
  logic [31:0]         ram_din_d;
  logic [31:0]         ram_dout_a;
  logic [31:0]         ram_dout_b;
  logic [31:0]         ram_dout_c;
  logic [31:0]         ram_dout_d;
  logic                busy;

  modport slave (
    input  req, req_wen, req_four, req_lock, req_addr, req_din,
    input  ram_dout_a, ram_dout_b, ram_dout_c, ram_dout_d,
    output gnt, rvalid, rdata, busy,
    output ram_wen, ram_ren, ram_four, ram_addr,
    output ram_din_a, ram_din_b, ram_din_c, ram_din_d
  );

  modport master (
    output req, req_wen, req_four, req_lock, req_addr, req_din,
    output ram_dout_a, ram_dout_b, ram_dout_c, ram_dout_d,
    input  gnt, rvalid, rdata, busy,
    input  ram_wen, ram_ren, ram_four, ram_addr,
    input  ram_din_a, ram_din_b, ram_din_c, ram_din_d
  );
endinterface

// File: rtl/qram_arbiter.sv
// rtl/qram_arbiter.sv - round-robin arbiter with grant locking for a quad-port RAM controller
module qram_arbiter #(
  parameter int NREQ     = 3,
  parameter int MAX_LOCK = 16
) (
  input  logic          clk,
  input  logic          nreset,
  qram_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_LOCK + 1);

  typedef enum logic { ARB = 1'b0, LOCKED = 1'b1 } state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;
  logic [CW-1:0] lock_cnt;
  logic          rd_pend;
  logic [PW-1:0] rd_id;

  logic          hit;
  logic [PW-1:0] sel;
  int            j;
  int            sel_i;
  logic          sel_four;

  function automatic logic [PW-1:0] next_id(input logic [PW-1:0] id);
    return (id == PW'(NREQ - 1)) ? '0 : id + 1'b1;
  endfunction

  always_comb begin
    hit = 1'b0;
    sel = '0;
    j   = 0;
    if (state == ARB) begin
      for (int k = 0; k < NREQ; k++) begin
        j = int'(ptr) + k;
        if (j >= NREQ) j = j - NREQ;
        if (!hit && bus.req[j]) begin
          hit = 1'b1;
          sel = PW'(j);
        end
      end
    end else if (bus.req[owner]) begin
      hit = 1'b1;
      sel = owner;
    end
    // Reset masks every grant so nothing reaches the RAM controller.
    if (!nreset) hit = 1'b0;
  end

  assign sel_i    = int'(sel);
  assign sel_four = bus.req_four[sel];

  assign bus.gnt       = hit ? (NREQ'(1) << sel) : '0;
  assign bus.ram_wen   = hit & bus.req_wen[sel];
  assign bus.ram_ren   = hit & ~bus.req_wen[sel];
  assign bus.ram_four  = hit & sel_four;
  assign bus.ram_addr  = hit ? bus.req_addr[16*sel_i +: 16] : '0;
  assign bus.ram_din_a = hit ? bus.req_din[128*sel_i +: 32] : '0;
  assign bus.ram_din_b = (hit && sel_four) ? bus.req_din[128*sel_i+32 +: 32] : '0;
  assign bus.ram_din_c = (hit && sel_four) ? bus.req_din[128*sel_i+64 +: 32] : '0;
  assign bus.ram_din_d = (hit && sel_four) ? bus.req_din[128*sel_i+96 +: 32] : '0;

  assign bus.rvalid = rd_pend ? (NREQ'(1) << rd_id) : '0;
  assign bus.rdata  = {bus.ram_dout_d, bus.ram_dout_c, bus.ram_dout_b, bus.ram_dout_a};
  assign bus.busy   = (state == LOCKED) | rd_pend;

  // lock_cnt counts grants already given to the owner; the grant that
  // brings the run to MAX_LOCK is the last one before a forced release.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state    <= ARB;
      ptr      <= '0;
      owner    <= '0;
      lock_cnt <= '0;
      rd_pend  <= 1'b0;
      rd_id    <= '0;
    end else begin
      rd_pend <= hit & ~bus.req_wen[sel];
      rd_id   <= sel;
      case (state)
        ARB: begin
          if (hit) begin
            ptr <= next_id(sel);
            if (bus.req_lock[sel] && MAX_LOCK > 1) begin
              state    <= LOCKED;
              owner    <= sel;
              lock_cnt <= CW'(1);
            end
          end
        end
        LOCKED: begin
          if (!hit || !bus.req_lock[owner] || lock_cnt == CW'(MAX_LOCK - 1)) begin
            state    <= ARB;
            lock_cnt <= '0;
            ptr      <= next_id(owner);
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        default: state <= ARB;
      endcase
    end
  end
endmodule

// File: tb/tb_qram_arbiter.sv
// tb/tb_qram_arbiter.sv - scoreboard bench for qram_arbiter
module tb_qram_arbiter;
  localparam int NREQ     = 3;
  localparam int MAX_LOCK = 16;
  localparam int LOGN     = 2048;

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  qram_arbiter_if #(.NREQ(NREQ)) bus ();
  qram_arbiter #(.NREQ(NREQ), .MAX_LOCK(MAX_LOCK)) dut (.clk(clk), .nreset(nreset), .bus(bus));

  typedef struct { int cyc; int id; logic wen; logic four; logic [15:0] addr; logic [127:0] din; } iss_t;
  typedef struct { int cyc; int id; logic [127:0] data; } rd_t;

  iss_t iss_q[$];
  rd_t  rd_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_cyc = 0;
  logic mon_en = 1'b0;
  logic exp_busy_now = 1'b0;
  logic ren_q = 1'b0;
  logic [15:0] addr_q = '0;
  logic [NREQ-1:0] gnt_log [LOGN];
  logic [NREQ-1:0] rv_log  [LOGN];

  // Reference model state: plain integers, counted in grants.
  int   m_ptr = 0;
  bit   m_locked = 0;
  int   m_owner = 0;
  int   m_cnt = 0;
  bit   m_rd_pending = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [15:0] a, input int k);
    return {a, a ^ 16'(16'h1F3D * (k + 1))};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %h required %h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input logic [NREQ-1:0] r, input logic [NREQ-1:0] w,
                      input logic [NREQ-1:0] f, input logic [NREQ-1:0] l,
                      input logic [NREQ*16-1:0] a, input logic [NREQ*128-1:0] d,
                      input logic rst);
    int g;
    iss_t e;
    rd_t  re;
    @(posedge clk);
    #1;
    last_cyc     = cyc;
    nreset       = ~rst;
    bus.req      = r;
    bus.req_wen  = w;
    bus.req_four = f;
    bus.req_lock = l;
    bus.req_addr = a;
    bus.req_din  = d;
    if (ren_q)
      {bus.ram_dout_d, bus.ram_dout_c, bus.ram_dout_b, bus.ram_dout_a} =
        {mem_word(addr_q, 3), mem_word(addr_q, 2), mem_word(addr_q, 1), mem_word(addr_q, 0)};
    else
      {bus.ram_dout_d, bus.ram_dout_c, bus.ram_dout_b, bus.ram_dout_a} =
        {$urandom, $urandom, $urandom, $urandom};
    mon_en = 1'b1;
    g = -1;
    if (rst) begin
      m_ptr = 0; m_locked = 0; m_cnt = 0; m_rd_pending = 0;
      rd_q.delete();
      exp_busy_now = 1'b0;
    end else begin
      exp_busy_now = m_locked || m_rd_pending;
      if (!m_locked) begin
        for (int k = 0; k < NREQ; k++) begin
          if (r[(m_ptr + k) % NREQ]) begin
            g = (m_ptr + k) % NREQ;
            break;
          end
        end
      end else if (r[m_owner]) begin
        g = m_owner;
      end
      if (m_locked) begin
        if (g < 0 || !l[m_owner]) m_locked = 0;
        else begin
          m_cnt++;
          if (m_cnt == MAX_LOCK) m_locked = 0;
        end
        if (!m_locked) m_ptr = (m_owner + 1) % NREQ;
      end else if (g >= 0) begin
        m_ptr = (g + 1) % NREQ;
        if (l[g]) begin m_locked = 1; m_owner = g; m_cnt = 1; end
      end
      m_rd_pending = (g >= 0) && !w[g];
      if (g >= 0) begin
        e.cyc = cyc; e.id = g; e.wen = w[g]; e.four = f[g];
        e.addr = a[16*g +: 16];
        e.din  = f[g] ? d[128*g +: 128] : {96'h0, d[128*g +: 32]};
        iss_q.push_back(e);
        if (!w[g]) begin
          re.cyc = cyc + 1; re.id = g;
          re.data = {mem_word(e.addr, 3), mem_word(e.addr, 2), mem_word(e.addr, 1), mem_word(e.addr, 0)};
          rd_q.push_back(re);
        end
      end
    end
  endtask

  task automatic idle(input logic rst);
    step('0, '0, '0, '0, '0, '0, rst);
  endtask

  always @(negedge clk) begin
    iss_t e;
    rd_t  re;
    ren_q  = bus.ram_ren;
    addr_q = bus.ram_addr;
    if (cyc < LOGN) begin gnt_log[cyc] = bus.gnt; rv_log[cyc] = bus.rvalid; end
    if (mon_en) begin
      while (iss_q.size() > 0 && iss_q[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL issue_missed: cycle %0d got no grant, required grant to %0d", iss_q[0].cyc, iss_q[0].id);
        void'(iss_q.pop_front());
      end
      while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL rvalid_missed: cycle %0d got no rvalid, required rvalid for %0d", rd_q[0].cyc, rd_q[0].id);
        void'(rd_q.pop_front());
      end
      if (bus.gnt != '0) begin
        if (iss_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL issue_unexpected: got gnt %b required none", bus.gnt);
        end else begin
          e = iss_q.pop_front();
          chk("issue_cycle", 128'(cyc), 128'(e.cyc));
          chk("gnt", 128'(bus.gnt), 128'(NREQ'(1) << e.id));
          chk("ram_cmd", 128'({bus.ram_wen, bus.ram_ren, bus.ram_four, bus.ram_addr}),
              128'({e.wen, ~e.wen, e.four, e.addr}));
          chk("ram_din", {bus.ram_din_d, bus.ram_din_c, bus.ram_din_b, bus.ram_din_a}, e.din);
        end
      end else begin
        chk("ram_idle", 128'({bus.ram_wen, bus.ram_ren, bus.ram_four, bus.ram_addr,
                              bus.ram_din_a, bus.ram_din_b, bus.ram_din_c, bus.ram_din_d}), 128'(0));
      end
      if (bus.rvalid != '0) begin
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rvalid_unexpected: got rvalid %b required none", bus.rvalid);
        end else begin
          re = rd_q.pop_front();
          chk("rvalid_cycle", 128'(cyc), 128'(re.cyc));
          chk("rvalid", 128'(bus.rvalid), 128'(NREQ'(1) << re.id));
          chk("rdata", bus.rdata, re.data);
        end
      end
      chk("busy", 128'(bus.busy), 128'(exp_busy_now));
    end
  end

  initial begin
    logic [NREQ*16-1:0]  a;
    logic [NREQ*128-1:0] d;
    logic [NREQ-1:0] r, w, f, l;
    int s23, s21, s22, s24, s26, s25;
    logic [NREQ-1:0] seq21 [6];
    seq21 = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    nreset = 1'b0;
    bus.req = '0; bus.req_wen = '0; bus.req_four = '0; bus.req_lock = '0;
    bus.req_addr = '0; bus.req_din = '0;
    bus.ram_dout_a = '0; bus.ram_dout_b = '0; bus.ram_dout_c = '0; bus.ram_dout_d = '0;

    // Reset with every requester asking: no grant may leak out.
    step(3'b111, 3'b000, 3'b111, 3'b000, '0, '0, 1'b1);
    step(3'b111, 3'b000, 3'b111, 3'b000, '0, '0, 1'b1);

    // Locked owner 0 against a persistent requester 2.
    for (int k = 0; k < 17; k++) begin
      step(3'b101, 3'b111, 3'b000, 3'b001, '0, '0, 1'b0);
      if (k == 0) s23 = last_cyc;
    end
    idle(1'b0);

    // All three requesting without lock: strict rotation.
    for (int k = 0; k < 6; k++) begin
      step(3'b111, 3'b111, 3'b000, 3'b000, '0, '0, 1'b0);
      if (k == 0) s21 = last_cyc;
    end
    idle(1'b0);

    // Four-word read by requester 1.
    a = '0; a[31:16] = 16'h0010;
    step(3'b010, 3'b000, 3'b010, 3'b000, a, '0, 1'b0);
    s22 = last_cyc;
    idle(1'b0);

    // Single-word write by requester 0; upper data lanes must be suppressed.
    a = '0; a[15:0] = 16'h0003;
    d = '0; d[127:0] = {96'hA5A5_A5A5_1234_5678_CAFE_F00D, 32'hDEAD_BEEF};
    step(3'b001, 3'b001, 3'b000, 3'b000, a, d, 1'b0);
    s24 = last_cyc;
    idle(1'b0);

    // Back-to-back reads from requesters 0 then 1.
    a = '0; a[15:0] = 16'h0100; a[31:16] = 16'h0200;
    step(3'b001, 3'b000, 3'b000, 3'b000, a, '0, 1'b0);
    s26 = last_cyc;
    step(3'b010, 3'b000, 3'b000, 3'b000, a, '0, 1'b0);
    idle(1'b0);

    // Read to requester 2 killed by a reset on the return cycle.
    a = '0; a[47:32] = 16'h0777;
    step(3'b100, 3'b000, 3'b000, 3'b000, a, '0, 1'b0);
    s25 = last_cyc;
    step(3'b111, 3'b000, 3'b000, 3'b000, '0, '0, 1'b1);
    step(3'b111, 3'b000, 3'b000, 3'b000, '0, '0, 1'b1);
    idle(1'b0);
    step(3'b111, 3'b111, 3'b000, 3'b000, '0, '0, 1'b0);
    idle(1'b0);

    // Random traffic with sticky locks and occasional resets.
    for (int n = 0; n < 500; n++) begin
      r = NREQ'($urandom);
      w = NREQ'($urandom);
      f = NREQ'($urandom);
      l = ($urandom_range(0, 3) != 0) ? '1 : NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) a[16*i +: 16] = 16'($urandom);
      for (int i = 0; i < 4*NREQ; i++) d[32*i +: 32] = $urandom;
      step(r, w, f, l, a, d, $urandom_range(0, 59) == 0);
    end
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);

    for (int k = 0; k < 16; k++) chk("lock_gnt0", 128'(gnt_log[s23 + k]), 128'(3'b001));
    chk("lock_release_gnt2", 128'(gnt_log[s23 + 16]), 128'(3'b100));
    for (int k = 0; k < 6; k++) chk("rr_sequence", 128'(gnt_log[s21 + k]), 128'(seq21[k]));
    chk("read_four_gnt", 128'(gnt_log[s22]), 128'(3'b010));
    chk("read_four_rvalid", 128'(rv_log[s22 + 1]), 128'(3'b010));
    chk("write_gnt", 128'(gnt_log[s24]), 128'(3'b001));
    chk("write_no_rvalid", 128'(rv_log[s24 + 1]), 128'(0));
    chk("b2b_rvalid0", 128'(rv_log[s26 + 1]), 128'(3'b001));
    chk("b2b_rvalid1", 128'(rv_log[s26 + 2]), 128'(3'b010));
    chk("reset_read_gnt", 128'(gnt_log[s25]), 128'(3'b100));
    for (int k = 1; k <= 3; k++) chk("reset_no_rvalid", 128'(rv_log[s25 + k]), 128'(0));
    chk("reset_gnt_off0", 128'(gnt_log[s25 + 1]), 128'(0));
    chk("reset_gnt_off1", 128'(gnt_log[s25 + 2]), 128'(0));
    chk("reset_ptr0", 128'(gnt_log[s25 + 4]), 128'(3'b001));
    chk("issue_queue_drained", 128'(iss_q.size()), 128'(0));
    chk("read_queue_drained", 128'(rd_q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
